icache_mem_port: RTL
====================

# icache_mem_port

Memory-controller responder for instruction-cache miss traffic: the memory-side end of the icache ↔ mem_ctrl block-request interface. Sits inside the memory controller between the icache miss port and the main-memory read port. Accepts icache block requests over valid/ready, buffers and de-duplicates them, issues one outstanding main-memory read at a time, and returns each block to the icache as a one-cycle response pulse. Supports a fetch-redirect flush that squashes pending and in-flight work.

## Interface
- `BLOCK_ADDR_WIDTH`, default 29: block address width (32-bit address minus 3 offset bits).
- `BLOCK_DATA_WIDTH`, default 64: cache block width in bits.
- `QDEPTH`, default 2: request queue entries (power of two, ≥2).
- `clk` in 1: clock, all state on rising edge.
- `rst_aL` in 1: reset, synchronous, active-low.
- `icache_req_valid` in 1: icache miss request valid.
- `icache_req_block_addr` in BLOCK_ADDR_WIDTH: requested block.
- `icache_req_ready` out 1: request accepted when valid && ready.
- `icache_resp_valid` out 1: one-cycle response pulse; icache applies no backpressure.
- `icache_resp_block_addr` out BLOCK_ADDR_WIDTH: block being returned.
- `icache_resp_block_data` out BLOCK_DATA_WIDTH: block data.
- `flush` in 1: fetch redirect; squash all pending/in-flight requests.
- `mem_req_valid` out 1: main-memory read request valid.
- `mem_req_block_addr` out BLOCK_ADDR_WIDTH: read address.
- `mem_req_ready` in 1: main memory accepts request.
- `mem_resp_valid` in 1: main-memory read data valid (single pulse per accepted request).
- `mem_resp_block_data` in BLOCK_DATA_WIDTH: read data.
- `coalesce_cnt` out 8: saturating count of coalesced requests.

## Operation
- Request queue: circular FIFO, QDEPTH entries, pointers wrap modulo QDEPTH; full/empty from an occupancy counter (0..QDEPTH).
- `icache_req_ready` = !full && !flush (combinational from state and flush only, never from `icache_req_valid`).
- Coalescing: accepted request whose address equals the in-service address (state ISSUE/WAIT) or any valid queue entry is not enqueued; `coalesce_cnt` increments, saturating at 255.
- FSM states: IDLE, ISSUE, WAIT, DRAIN, RESP.
  - IDLE: if queue non-empty → ISSUE, latching the head address into the service register.
  - ISSUE: `mem_req_valid`=1, address held stable; on `mem_req_ready` → WAIT.
  - WAIT: on `mem_resp_valid` → RESP, registering data and address; pop queue head on this edge.
  - RESP: `icache_resp_valid`=1 for exactly this cycle; → ISSUE (latch new head) if queue non-empty after pop, else IDLE.
  - DRAIN: wait for squashed response; on `mem_resp_valid` discard → IDLE.
- Flush: clears queue and occupancy same edge. ISSUE → IDLE (request withdrawn; legal only because not yet accepted). WAIT → DRAIN. DRAIN unchanged. RESP completes its pulse (already registered), then IDLE. `mem_resp_valid` and `flush` same cycle in WAIT: response discarded, → IDLE.
- Request arriving while in DRAIN is accepted and queued normally; issued after DRAIN exits.
- Reset (any state, including mid-transaction): queue empty, FSM IDLE, all outputs 0, `coalesce_cnt`=0. An in-flight main-memory response arriving after reset is ignored (IDLE ignores `mem_resp_valid`).

## Timing
- Accept at edge N, empty queue, IDLE: `mem_req_valid` high in cycle N+1.
- mem request accepted at edge K: WAIT from K+1.
- `mem_resp_valid` at edge M: `icache_resp_valid` high in cycle M+1 (one registered stage).
- Minimum accept-to-response: 2 cycles + main-memory latency.
- Back-to-back: next queued request's `mem_req_valid` asserts in cycle M+2.
- All outputs registered except `icache_req_ready`.
- Exactly one main-memory request outstanding at any time.

## Test plan
- Single miss: req 0x2032 at cycle 2, mem ready immediately, mem latency 4 → `mem_req_valid` cycle 3, `icache_resp_valid` one cycle with addr 0x2032 and exact data, FSM back to IDLE.
- Queue full: 3 distinct addrs back-to-back with mem_req_ready=0 → third sees ready=0 until first popped; responses return in order 0x2031, 0x2032, 0x2033.
- Coalescing: req 0x2031 twice while in WAIT → one mem request, one response, `coalesce_cnt`=1; 300 dup requests → saturates at 255.
- Flush in WAIT: flush after mem accept, new req 0x2040 next cycle → stale response discarded (no icache pulse), then 0x2040 issued and returned.
- Flush in ISSUE with mem_req_ready=0 → `mem_req_valid` drops next cycle, no response; flush with simultaneous req → req not accepted.
- Reset mid-WAIT (rst_aL low one cycle) → all outputs 0 next cycle; late `mem_resp_valid` produces no icache response.

Source files
------------

// File: rtl/icache_mem_port.sv
// Memory-controller responder for icache block misses: queues and de-duplicates
// block requests, keeps one main-memory read in flight, returns each block as a pulse.
module icache_mem_port #(
    parameter int BLOCK_ADDR_WIDTH = 29,
    parameter int BLOCK_DATA_WIDTH = 64,
    parameter int QDEPTH           = 2
) (
    input  logic                        clk,
    input  logic                        rst_aL,
    input  logic                        icache_req_valid,
    input  logic [BLOCK_ADDR_WIDTH-1:0] icache_req_block_addr,
    output logic                        icache_req_ready,
    output logic                        icache_resp_valid,
    output logic [BLOCK_ADDR_WIDTH-1:0] icache_resp_block_addr,
    output logic [BLOCK_DATA_WIDTH-1:0] icache_resp_block_data,
    input  logic                        flush,
    output logic                        mem_req_valid,
    output logic [BLOCK_ADDR_WIDTH-1:0] mem_req_block_addr,
    input  logic                        mem_req_ready,
    input  logic                        mem_resp_valid,
    input  logic [BLOCK_DATA_WIDTH-1:0] mem_resp_block_data,
    output logic [7:0]                  coalesce_cnt
);
    localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CW = PW + 1;

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, DRAIN, RESP} state_t;

    state_t                        state_reg, state_next;
    logic [BLOCK_ADDR_WIDTH-1:0]   q_addr_reg [QDEPTH];
    logic [QDEPTH-1:0]             q_valid_reg;
    logic [PW-1:0]                 head_reg, tail_reg;
    logic [CW-1:0]                 count_reg;
    logic [BLOCK_ADDR_WIDTH-1:0]   svc_addr_reg, svc_addr_next;
    logic                          mem_req_valid_reg;
    logic                          resp_valid_reg;
    logic [BLOCK_ADDR_WIDTH-1:0]   resp_addr_reg;
    logic [BLOCK_DATA_WIDTH-1:0]   resp_data_reg;
    logic [7:0]                    coalesce_cnt_reg;

    logic [QDEPTH-1:0] hit;
    logic              full, empty, accept, svc_hit, dup, push, coalesce, pop, capture;

    assign full             = (count_reg == CW'(QDEPTH));
    assign empty            = (count_reg == '0);
    assign icache_req_ready = !full && !flush;

    // Duplicate detection against every live queue entry in parallel.
    genvar gi;
    generate
        for (gi = 0; gi < QDEPTH; gi++) begin : g_match
            assign hit[gi] = q_valid_reg[gi] && (q_addr_reg[gi] == icache_req_block_addr);
        end
    endgenerate

    assign svc_hit  = ((state_reg == ISSUE) || (state_reg == WAIT)) &&
                      (svc_addr_reg == icache_req_block_addr);
    assign accept   = icache_req_valid && icache_req_ready;
    assign dup      = svc_hit || (|hit);
    assign push     = accept && !dup;
    assign coalesce = accept && dup;

    always_comb begin
        state_next    = state_reg;
        svc_addr_next = svc_addr_reg;
        pop           = 1'b0;
        capture       = 1'b0;
        case (state_reg)
            IDLE: begin
                // A request accepted on this edge into an empty queue issues next cycle.
                if (!flush && !empty) begin
                    state_next    = ISSUE;
                    svc_addr_next = q_addr_reg[head_reg];
                end else if (push) begin
                    state_next    = ISSUE;
                    svc_addr_next = icache_req_block_addr;
                end
            end
            ISSUE: begin
                // Once memory has taken the read, a flush must wait out its response.
                if (mem_req_ready)
                    state_next = flush ? DRAIN : WAIT;
                else if (flush)
                    state_next = IDLE;
            end
            WAIT: begin
                if (mem_resp_valid) begin
                    if (flush) begin
                        state_next = IDLE;
                    end else begin
                        state_next = RESP;
                        pop        = 1'b1;
                        capture    = 1'b1;
                    end
                end else if (flush) begin
                    state_next = DRAIN;
                end
            end
            RESP: begin
                if (flush) begin
                    state_next = IDLE;
                end else if (!empty) begin
                    state_next    = ISSUE;
                    svc_addr_next = q_addr_reg[head_reg];
                end else if (push) begin
                    state_next    = ISSUE;
                    svc_addr_next = icache_req_block_addr;
                end
            end
            DRAIN: begin
                if (mem_resp_valid)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_aL) begin
            state_reg         <= IDLE;
            head_reg          <= '0;
            tail_reg          <= '0;
            count_reg         <= '0;
            q_valid_reg       <= '0;
            svc_addr_reg      <= '0;
            mem_req_valid_reg <= 1'b0;
            resp_valid_reg    <= 1'b0;
            resp_addr_reg     <= '0;
            resp_data_reg     <= '0;
            coalesce_cnt_reg  <= '0;
        end else begin
            state_reg         <= state_next;
            svc_addr_reg      <= svc_addr_next;
            mem_req_valid_reg <= (state_next == ISSUE);
            resp_valid_reg    <= capture;
            if (capture) begin
                resp_addr_reg <= svc_addr_reg;
                resp_data_reg <= mem_resp_block_data;
            end
            if (flush) begin
                head_reg    <= '0;
                tail_reg    <= '0;
                count_reg   <= '0;
                q_valid_reg <= '0;
            end else begin
                if (push) begin
                    q_valid_reg[tail_reg] <= 1'b1;
                    tail_reg              <= tail_reg + PW'(1);
                end
                if (pop) begin
                    q_valid_reg[head_reg] <= 1'b0;
                    head_reg              <= head_reg + PW'(1);
                end
                count_reg <= count_reg + CW'(push) - CW'(pop);
            end
            if (coalesce && (coalesce_cnt_reg != 8'hFF))
                coalesce_cnt_reg <= coalesce_cnt_reg + 8'd1;
        end
    end

    // Queue payload needs no reset; liveness is tracked by q_valid_reg.
    always_ff @(posedge clk) begin
        if (push)
            q_addr_reg[tail_reg] <= icache_req_block_addr;
    end

    assign mem_req_valid          = mem_req_valid_reg;
    assign mem_req_block_addr     = svc_addr_reg;
    assign icache_resp_valid      = resp_valid_reg;
    assign icache_resp_block_addr = resp_addr_reg;
    assign icache_resp_block_data = resp_data_reg;
    assign coalesce_cnt           = coalesce_cnt_reg;
endmodule
